bin_to_bcd_300: RTL and testbench

- Sequential binary-to-packed-BCD converter. Uses shift-and-add-3 (double-dabble), one bit per clock.
- Produces the 40-bit packed BCD words that the downstream BCD-to-decimal stage consumes. Sits on the transmit side of that BCD interface.
- Matches that stage's 300-sample session budget: accepts at most MAX_CONV conversions per reset.
- Simple start/ready/valid handshake toward the producer and consumer.

---
 rtl/bin_to_bcd_300.sv | 110 +++++++++++
 tb/tb_bin_to_bcd_300.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_300.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_300
// Brief    : Sequential binary-to-packed-BCD converter (double-dabble, one bit
//            per clock) with a per-reset conversion budget.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_300 #(
    parameter int BIN_WIDTH = 32,
    parameter int DIGITS    = 10,
    parameter int MAX_CONV  = 300,
    parameter int CNT_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [BIN_WIDTH-1:0]   bin_in,
    output logic                   ready,
    output logic                   valid,
    output logic [4*DIGITS-1:0]    bcd_out,
    output logic [CNT_WIDTH-1:0]   conv_count,
    output logic                   limit_reached
);

    localparam int                   c_BC_W   = $clog2(BIN_WIDTH + 1);
    localparam logic [c_BC_W-1:0]    c_BITS   = c_BC_W'(BIN_WIDTH);
    localparam logic [c_BC_W-1:0]    c_BC_ONE = c_BC_W'(1);
    localparam logic [CNT_WIDTH-1:0] c_MAX    = CNT_WIDTH'(MAX_CONV);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                 r_state;
    logic [BIN_WIDTH-1:0]   r_bin;
    logic [4*DIGITS-1:0]    r_scratch;
    logic [c_BC_W-1:0]      r_bit_cnt;
    logic                   r_ready;
    logic                   r_valid;
    logic [4*DIGITS-1:0]    r_bcd;
    logic [CNT_WIDTH-1:0]   r_count;
    logic                   r_limit;

    logic [4*DIGITS-1:0]    w_adj;
    logic [4*DIGITS-1:0]    w_scratch_next;
    logic [BIN_WIDTH-1:0]   w_bin_next;
    logic [CNT_WIDTH-1:0]   w_count_inc;

    // Add-3 on every digit that would reach 10 or more after the upcoming doubling.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                  (r_scratch[4*gi +: 4] + 4'd3) :
                                  r_scratch[4*gi +: 4];
    end

    assign w_scratch_next = {w_adj[4*DIGITS-2:0], r_bin[BIN_WIDTH-1]};
    assign w_bin_next     = {r_bin[BIN_WIDTH-2:0], 1'b0};
    assign w_count_inc    = r_count + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_bin     <= '0;
            r_scratch <= '0;
            r_bit_cnt <= '0;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            r_bcd     <= '0;
            r_count   <= '0;
            r_limit   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && r_ready) begin
                        r_bin     <= bin_in;
                        r_scratch <= '0;
                        r_bit_cnt <= c_BITS;
                        r_ready   <= 1'b0;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_scratch_next;
                    r_bin     <= w_bin_next;
                    r_bit_cnt <= r_bit_cnt - 1'b1;
                    // Last iteration: publish result and reopen unless the budget is spent.
                    if (r_bit_cnt == c_BC_ONE) begin
                        r_bcd   <= w_scratch_next;
                        r_valid <= 1'b1;
                        r_count <= w_count_inc;
                        r_limit <= (w_count_inc == c_MAX);
                        r_ready <= (w_count_inc < c_MAX);
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready         = r_ready;
    assign valid         = r_valid;
    assign bcd_out       = r_bcd;
    assign conv_count    = r_count;
    assign limit_reached = r_limit;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_300.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_300
// Brief    : Directed self-checking bench for bin_to_bcd_300.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_300;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] bin_in;
    logic        ready;
    logic        valid;
    logic [39:0] bcd_out;
    logic [8:0]  conv_count;
    logic        limit_reached;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_300 dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .bin_in        (bin_in),
        .ready         (ready),
        .valid         (valid),
        .bcd_out       (bcd_out),
        .conv_count    (conv_count),
        .limit_reached (limit_reached)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Decimal digits by repeated division.
    function automatic logic [39:0] ref_bcd(input logic [31:0] v);
        logic [63:0] x;
        logic [39:0] r;
        x = {32'd0, v};
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic accept(input logic [31:0] v);
        int n;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) check("accept_ready", {63'd0, ready}, 64'd1);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Number of extra negedges until valid is sampled high; -1 on timeout.
    task automatic wait_valid(output int waited);
        int n;
        n = 0;
        while (!valid && n < 45) begin
            @(negedge clk);
            n++;
        end
        waited = valid ? n : -1;
        if (!valid) check("valid_timeout", {63'd0, valid}, 64'd1);
    endtask

    task automatic convert_check(input string tag, input logic [31:0] v, input logic [39:0] exp);
        int w;
        accept(v);
        wait_valid(w);
        check(tag, {24'd0, bcd_out}, {24'd0, exp});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, {63'd0, ready}, 64'd1);
        check({tag, "_valid"}, {63'd0, valid}, 64'd0);
        check({tag, "_bcd"}, {24'd0, bcd_out}, 64'd0);
        check({tag, "_count"}, {55'd0, conv_count}, 64'd0);
        check({tag, "_limit"}, {63'd0, limit_reached}, 64'd0);
    endtask

    initial begin
        int          w;
        bit          saw;
        logic [31:0] vals [300];
        logic [39:0] last;

        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;
        @(negedge clk);

        // Basic conversion with latency and pulse width.
        accept(32'd300);
        wait_valid(w);
        check("basic_latency", 64'(w), 64'd32);
        check("basic_bcd", {24'd0, bcd_out}, 64'h0000000300);
        check("basic_count", {55'd0, conv_count}, 64'd1);
        check("basic_ready_in_valid", {63'd0, ready}, 64'd1);
        @(negedge clk);
        check("basic_valid_one_cycle", {63'd0, valid}, 64'd0);
        check("basic_bcd_hold", {24'd0, bcd_out}, 64'h0000000300);

        convert_check("zero", 32'd0, 40'h0000000000);
        convert_check("max", 32'hFFFFFFFF, 40'h4294967295);
        convert_check("n99", 32'd99, 40'h0000000099);
        convert_check("n100", 32'd100, 40'h0000000100);
        check("count_after5", {55'd0, conv_count}, 64'd5);

        // Start pulses during SHIFT must be ignored.
        accept(32'd1234);
        repeat (3) @(negedge clk);
        start = 1'b1; bin_in = 32'd777;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; bin_in = 32'd5555;
        @(negedge clk);
        start = 1'b0;
        wait_valid(w);
        check("ignore_bcd", {24'd0, bcd_out}, 64'h0000001234);
        check("ignore_count", {55'd0, conv_count}, 64'd6);

        // Start held in the valid cycle is accepted.
        start = 1'b1; bin_in = 32'd9;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", {63'd0, ready}, 64'd0);
        wait_valid(w);
        check("b2b_latency", 64'(w), 64'd32);
        check("b2b_bcd", {24'd0, bcd_out}, 64'h0000000009);
        check("b2b_count", {55'd0, conv_count}, 64'd7);

        // Asynchronous reset mid-conversion.
        accept(32'd12345);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (valid) saw = 1'b1;
        end
        check("midrst_no_valid", {63'd0, saw}, 64'd0);
        check("midrst_count", {55'd0, conv_count}, 64'd0);
        convert_check("after_rst", 32'd12345, 40'h0000012345);
        check("after_rst_count", {55'd0, conv_count}, 64'd1);

        // Budget: 300 back-to-back conversions from a fresh reset.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 300; i++) vals[i] = $urandom;
        vals[0] = 32'hFFFFFFFF;
        vals[1] = 32'd0;
        accept(vals[0]);
        for (int i = 0; i < 300; i++) begin
            wait_valid(w);
            check($sformatf("budget_bcd_%0d", i), {24'd0, bcd_out}, {24'd0, ref_bcd(vals[i])});
            if (i < 299) begin
                start = 1'b1; bin_in = vals[i+1];
                @(negedge clk);
                start = 1'b0;
            end
        end
        last = ref_bcd(vals[299]);
        check("budget_count", {55'd0, conv_count}, 64'd300);
        check("budget_limit", {63'd0, limit_reached}, 64'd1);
        check("budget_ready", {63'd0, ready}, 64'd0);
        start = 1'b1; bin_in = 32'd42;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (valid) saw = 1'b1;
        end
        start = 1'b0;
        check("budget_301_no_valid", {63'd0, saw}, 64'd0);
        check("budget_301_bcd", {24'd0, bcd_out}, {24'd0, last});
        check("budget_301_count", {55'd0, conv_count}, 64'd300);
        check("budget_301_ready", {63'd0, ready}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
